// File: rtl/display_pkg.sv
// Shared encodings for the register display front-end: debouncer states,
// view modes and the active-low hex-to-7-segment font.
package display_pkg;

   typedef enum logic [1:0] {
      DB_IDLE         = 2'd0,
      DB_WAIT_PRESS   = 2'd1,
      DB_PRESSED      = 2'd2,
      DB_WAIT_RELEASE = 2'd3
   } db_state_t;

   typedef enum logic [1:0] {
      VIEW_REG   = 2'd0,
      VIEW_PC    = 2'd1,
      VIEW_INSTR = 2'd2
   } view_mode_t;

   localparam int NUM_DIGITS = 8;

   // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer feeding a debounce FSM that
// emits a one-cycle pulse when a press has been stable for DEBOUNCE_CYCLES.
module btn_debounce
   import display_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic level,
   output logic pulse
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_reg;
   logic          sync2_reg;
   db_state_t     state_reg;
   db_state_t     state_next;
   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] cnt_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         state_reg <= DB_IDLE;
         cnt_reg   <= '0;
      end else begin
         sync1_reg <= btn;
         sync2_reg <= sync1_reg;
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // A level change in the synced input always restarts the count, so a
   // bounce shorter than the window never reaches the terminal value.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg + 1'b1;
      pulse      = 1'b0;
      case (state_reg)
         DB_IDLE: begin
            cnt_next = '0;
            if (sync2_reg) state_next = DB_WAIT_PRESS;
         end
         DB_WAIT_PRESS: begin
            if (!sync2_reg) begin
               state_next = DB_IDLE;
               cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = DB_PRESSED;
               cnt_next   = '0;
               pulse      = 1'b1;
            end
         end
         DB_PRESSED: begin
            cnt_next = '0;
            if (!sync2_reg) state_next = DB_WAIT_RELEASE;
         end
         DB_WAIT_RELEASE: begin
            if (sync2_reg) begin
               state_next = DB_PRESSED;
               cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = DB_IDLE;
               cnt_next   = '0;
            end
         end
         default: begin
            state_next = DB_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   assign level = (state_reg == DB_PRESSED) || (state_reg == DB_WAIT_RELEASE);

endmodule

// File: rtl/reg_display_ctrl.sv
// Debug display front-end: buttons step a register index, the read value is
// latched and scanned onto an 8-digit 7-seg display. DBG_PC_VIEW_EN adds PC/instr views.
module reg_display_ctrl
   import display_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REFRESH_DIV     = 50000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btn_next,
   input  logic        btn_prev,
`ifdef DBG_PC_VIEW_EN
   input  logic        btn_mode,
   input  logic [31:0] pc_in,
   input  logic [31:0] instr_in,
   output logic [1:0]  view_mode,
`endif
   input  logic [31:0] debug_reg_data_in,
   output logic [4:0]  debug_reg_read_addr_out,
   output logic [4:0]  led_idx,
   output logic [6:0]  seg_n,
   output logic [7:0]  an_n
);

`ifdef DBG_PC_VIEW_EN
   localparam int NUM_BTN = 3;
`else
   localparam int NUM_BTN = 2;
`endif
   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

   logic [NUM_BTN-1:0] btn_raw;
   logic [NUM_BTN-1:0] btn_pulse;
   logic [NUM_BTN-1:0] unused_level;

   logic [4:0]    idx_reg;
   logic [4:0]    idx_next;
   logic          reload_reg;
   logic [31:0]   snapshot_reg;
   logic [PW-1:0] presc_reg;
   logic [2:0]    ptr_reg;
   logic [7:0]    an_reg;
   logic [6:0]    seg_reg;

   logic          reg_mode;
   logic          mode_changed;
   logic [31:0]   snap_src;
   logic          step_up;
   logic          step_down;
   logic          presc_tc;
   logic          frame_wrap;

   assign btn_raw[0] = btn_next;
   assign btn_raw[1] = btn_prev;
`ifdef DBG_PC_VIEW_EN
   assign btn_raw[2] = btn_mode;
`endif

   generate
      for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
         btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .btn   (btn_raw[gi]),
            .level (unused_level[gi]),
            .pulse (btn_pulse[gi])
         );
      end
   endgenerate

`ifdef DBG_PC_VIEW_EN
   view_mode_t mode_reg;
   view_mode_t mode_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) mode_reg <= VIEW_REG;
      else       mode_reg <= mode_next;
   end

   always_comb begin
      mode_next = mode_reg;
      if (btn_pulse[2]) begin
         case (mode_reg)
            VIEW_REG: mode_next = VIEW_PC;
            VIEW_PC:  mode_next = VIEW_INSTR;
            default:  mode_next = VIEW_REG;
         endcase
      end
   end

   always_comb begin
      case (mode_reg)
         VIEW_PC:    snap_src = pc_in;
         VIEW_INSTR: snap_src = instr_in;
         default:    snap_src = debug_reg_data_in;
      endcase
   end

   assign reg_mode     = (mode_reg == VIEW_REG);
   assign mode_changed = (mode_next != mode_reg);
   assign view_mode    = mode_reg;
`else
   assign reg_mode     = 1'b1;
   assign mode_changed = 1'b0;
   assign snap_src     = debug_reg_data_in;
`endif

   // Simultaneous next+prev cancel out rather than racing.
   assign step_up   = btn_pulse[0] & ~btn_pulse[1] & reg_mode;
   assign step_down = btn_pulse[1] & ~btn_pulse[0] & reg_mode;

   always_comb begin
      idx_next = idx_reg;
      if (step_up)        idx_next = idx_reg + 5'd1;
      else if (step_down) idx_next = idx_reg - 5'd1;
   end

   assign presc_tc   = (presc_reg == PRESC_LAST);
   assign frame_wrap = presc_tc && (ptr_reg == 3'd7);

   // The snapshot waits one cycle after an index/mode change so the core's
   // combinational read data reflects the new address before it is latched.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_reg      <= '0;
         reload_reg   <= 1'b0;
         snapshot_reg <= '0;
         presc_reg    <= '0;
         ptr_reg      <= '0;
         an_reg       <= 8'hFE;
         seg_reg      <= 7'h40;
      end else begin
         idx_reg    <= idx_next;
         reload_reg <= (idx_next != idx_reg) || mode_changed;
         presc_reg  <= presc_tc ? '0 : presc_reg + 1'b1;
         if (presc_tc) ptr_reg <= ptr_reg + 3'd1;
         if (reload_reg || frame_wrap) snapshot_reg <= snap_src;
         an_reg  <= ~(8'b1 << ptr_reg);
         seg_reg <= hex_to_seg(snapshot_reg[{ptr_reg, 2'b00} +: 4]);
      end
   end

   assign debug_reg_read_addr_out = idx_reg;
   assign led_idx                 = idx_reg;
   assign an_n                    = an_reg;
   assign seg_n                   = seg_reg;

endmodule

// File: tb/tb_reg_display_ctrl.sv
// Scoreboard bench for reg_display_ctrl: stimulus pushes expected address
// steps and display slots; a negedge monitor pops and compares them.
module tb_reg_display_ctrl;

   localparam int DEB = 4;
   localparam int RDIV = 2;

   logic        clk;
   logic        reset;
   logic        btn_next;
   logic        btn_prev;
   logic [31:0] debug_reg_data_in;
   logic [4:0]  debug_reg_read_addr_out;
   logic [4:0]  led_idx;
   logic [6:0]  seg_n;
   logic [7:0]  an_n;
`ifdef DBG_PC_VIEW_EN
   logic        btn_mode;
   logic [31:0] pc_in;
   logic [31:0] instr_in;
   logic [1:0]  view_mode;
`endif

   logic [31:0] regs [32];
   assign debug_reg_data_in = regs[debug_reg_read_addr_out];

   reg_display_ctrl #(
      .DEBOUNCE_CYCLES(DEB),
      .REFRESH_DIV    (RDIV)
   ) dut (
      .clk                     (clk),
      .reset                   (reset),
      .btn_next                (btn_next),
      .btn_prev                (btn_prev),
`ifdef DBG_PC_VIEW_EN
      .btn_mode                (btn_mode),
      .pc_in                   (pc_in),
      .instr_in                (instr_in),
      .view_mode               (view_mode),
`endif
      .debug_reg_data_in       (debug_reg_data_in),
      .debug_reg_read_addr_out (debug_reg_read_addr_out),
      .led_idx                 (led_idx),
      .seg_n                   (seg_n),
      .an_n                    (an_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [4:0] val;
      int         at;
   } addr_exp_t;

   typedef struct {
      logic [7:0] an;
      logic [6:0] seg;
   } disp_exp_t;

   addr_exp_t addr_q[$];
   disp_exp_t disp_q[$];
   int n_checks = 0;
   int n_pass = 0;
   int arm_count = 0;
   int arm_seen = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [6:0] exp_seg(input logic [3:0] h);
      case (h)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   // Monitor: address steps and display slots are compared as they appear.
   logic [4:0] prev_addr = 5'd0;
   logic [7:0] prev_an = 8'hFE;
   bit         frame_active = 1'b0;
   always @(negedge clk) begin
      addr_exp_t ea;
      disp_exp_t ed;
      if (debug_reg_read_addr_out !== prev_addr) begin
         if (addr_q.size() == 0) begin
            n_checks++;
            $display("FAIL addr_unexpected: got %0d expected %0d held (cycle %0d)",
                     debug_reg_read_addr_out, prev_addr, cyc);
         end else begin
            ea = addr_q.pop_front();
            check("addr_val", {27'd0, debug_reg_read_addr_out}, {27'd0, ea.val});
            check("led_idx", {27'd0, led_idx}, {27'd0, ea.val});
            check("addr_cycle", cyc, ea.at);
         end
         $display("addr -> %0d at cycle %0d", debug_reg_read_addr_out, cyc);
         prev_addr = debug_reg_read_addr_out;
      end
      if (an_n !== prev_an) begin
         if (arm_seen != arm_count && an_n == 8'hFE) begin
            frame_active = 1'b1;
            arm_seen = arm_count;
         end
         if (frame_active && disp_q.size() != 0) begin
            ed = disp_q.pop_front();
            check("disp_an", {24'd0, an_n}, {24'd0, ed.an});
            check("disp_seg", {25'd0, seg_n}, {25'd0, ed.seg});
            $display("slot an_n=%h seg_n=%h (exp %h/%h)", an_n, seg_n, ed.an, ed.seg);
            if (disp_q.size() == 0) frame_active = 1'b0;
         end
         prev_an = an_n;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_btn(input int which, input logic v);
      case (which)
         0: btn_next = v;
         1: btn_prev = v;
`ifdef DBG_PC_VIEW_EN
         2: btn_mode = v;
`endif
         default: ;
      endcase
   endtask

   task automatic wait_addr_done();
      for (int i = 0; i < 100 && addr_q.size() != 0; i++) tick(1);
      check("addr_queue_drained", addr_q.size(), 0);
      addr_q.delete();
   endtask

   // Hold a button long enough for one debounced press, then release it.
   task automatic press(input int which, input bit expect_step, input logic [4:0] exp_val);
      addr_exp_t e;
      if (expect_step) begin
         e.val = exp_val;
         e.at  = cyc + 2 + DEB + 1;
         addr_q.push_back(e);
      end
      set_btn(which, 1'b1);
      tick(8);
      set_btn(which, 1'b0);
      tick(12);
      wait_addr_done();
   endtask

   task automatic push_frame(input logic [31:0] data);
      disp_exp_t e;
      for (int k = 0; k < 8; k++) begin
         e.an  = ~(8'b1 << k);
         e.seg = exp_seg(data[4*k +: 4]);
         disp_q.push_back(e);
      end
   endtask

   task automatic wait_frames_done();
      for (int i = 0; i < 200 && (disp_q.size() != 0 || arm_seen != arm_count); i++) tick(1);
      check("frame_complete", {31'd0, (disp_q.size() == 0 && arm_seen == arm_count)}, 32'd1);
      disp_q.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      addr_exp_t e;
      for (int i = 0; i < 32; i++) regs[i] = 32'h0101_0101 * i;
      regs[5] = 32'h1234ABCD;
      btn_next = 1'b0;
      btn_prev = 1'b0;
`ifdef DBG_PC_VIEW_EN
      btn_mode = 1'b0;
      pc_in    = 32'h0000_0040;
      instr_in = 32'h0000_0013;
`endif
      reset = 1'b1;

      // 1. reset state held while reset is asserted
      for (int i = 0; i < 3; i++) begin
         tick(1);
         check("rst_addr", {27'd0, debug_reg_read_addr_out}, 32'd0);
         check("rst_led", {27'd0, led_idx}, 32'd0);
         check("rst_an", {24'd0, an_n}, 32'h0000_00FE);
         check("rst_seg", {25'd0, seg_n}, 32'h0000_0040);
      end
      reset = 1'b0;
      tick(3);

      // 2. glitch of 3 synced cycles: no step; then a real press steps to 1 after 7 cycles
      btn_next = 1'b1;
      tick(3);
      btn_next = 1'b0;
      tick(15);
      check("glitch_no_step", {27'd0, debug_reg_read_addr_out}, 32'd0);
      e.val = 5'd1;
      e.at  = cyc + 7;
      addr_q.push_back(e);
      btn_next = 1'b1;
      tick(10);
      btn_next = 1'b0;
      tick(15);
      wait_addr_done();

      // 3. wrap in both directions
      press(1, 1'b1, 5'd0);
      press(1, 1'b1, 5'd31);
      press(0, 1'b1, 5'd0);

      // 4. step to index 5 and check one full scanned frame
      for (int i = 1; i <= 5; i++) press(0, 1'b1, 5'(i));
      push_frame(32'h1234ABCD);
      arm_count++;
      wait_frames_done();

      // 5a. next and prev debounced in the same cycle: no change
      btn_next = 1'b1;
      btn_prev = 1'b1;
      tick(10);
      btn_next = 1'b0;
      btn_prev = 1'b0;
      tick(12);
      check("dual_press_hold", {27'd0, debug_reg_read_addr_out}, 32'd5);

      // 5b. data changes mid-frame: old frame completes, new data after the wrap
      push_frame(32'h1234ABCD);
      push_frame(32'hFEDC0123);
      arm_count++;
      for (int i = 0; i < 100 && !(arm_seen == arm_count && disp_q.size() <= 13); i++) tick(1);
      regs[5] = 32'hFEDC0123;
      wait_frames_done();

      // 6a. reset mid-debounce and mid-frame: immediate reset values, no late pulse
      btn_next = 1'b1;
      tick(4);
      #2;
      e.val = 5'd0;
      e.at  = cyc;
      addr_q.push_back(e);
      reset = 1'b1;
      #1;
      check("async_rst_an", {24'd0, an_n}, 32'h0000_00FE);
      check("async_rst_seg", {25'd0, seg_n}, 32'h0000_0040);
      check("async_rst_addr", {27'd0, debug_reg_read_addr_out}, 32'd0);
      btn_next = 1'b0;
      tick(3);
      reset = 1'b0;
      tick(20);
      check("no_pulse_after_rst", {27'd0, debug_reg_read_addr_out}, 32'd0);
      wait_addr_done();

      // 6b. button held through reset release: exactly one step
      btn_next = 1'b1;
      tick(1);
      reset = 1'b1;
      tick(2);
      e.val = 5'd1;
      e.at  = cyc + 7;
      addr_q.push_back(e);
      reset = 1'b0;
      tick(12);
      btn_next = 1'b0;
      tick(15);
      wait_addr_done();

`ifdef DBG_PC_VIEW_EN
      // PC view shows pc_in; next is ignored outside REG mode
      press(2, 1'b0, 5'd0);
      check("view_mode_pc", {30'd0, view_mode}, 32'd1);
      press(0, 1'b0, 5'd0);
      check("idx_held_in_pc", {27'd0, debug_reg_read_addr_out}, 32'd1);
      push_frame(32'h0000_0040);
      arm_count++;
      wait_frames_done();
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
